// File: rtl/cache_arb_pkg.sv
// Shared types and default geometry for the I/D cache line arbiter that feeds
// cacheline_adaptor.
package cache_arb_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned LINE_W_DEF   = 256;
    localparam int unsigned OFFSET_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        CLIENT_I = 1'b0,
        CLIENT_D = 1'b1
    } client_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter merging I-cache and D-cache line misses onto one
// line-granular memory port; one transaction in flight, all outputs registered.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned LINE_W   = LINE_W_DEF,
    parameter int unsigned OFFSET_W = OFFSET_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              imem_read,
    input  logic [ADDR_W-1:0] imem_address,
    output logic [LINE_W-1:0] imem_rdata,
    output logic              imem_resp,

    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_address,
    input  logic [LINE_W-1:0] dmem_wdata,
    output logic [LINE_W-1:0] dmem_rdata,
    output logic              dmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

    arb_state_t        state_q,        state_d;
    client_t           last_grant_q,   last_grant_d;
    logic              pmem_read_q,    pmem_read_d;
    logic              pmem_write_q,   pmem_write_d;
    logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
    logic [LINE_W-1:0] pmem_wdata_q,   pmem_wdata_d;
    logic [LINE_W-1:0] imem_rdata_q,   imem_rdata_d;
    logic [LINE_W-1:0] dmem_rdata_q,   dmem_rdata_d;
    logic              imem_resp_q,    imem_resp_d;
    logic              dmem_resp_q,    dmem_resp_d;

    logic    i_req;
    logic    d_req;
    client_t grant;

    assign i_req = imem_read;
    assign d_req = dmem_read | dmem_write;

    // Round-robin: on a tie the client that did not win last time goes next.
    always_comb begin
        if (i_req && d_req) begin
            grant = (last_grant_q == CLIENT_I) ? CLIENT_D : CLIENT_I;
        end else if (d_req) begin
            grant = CLIENT_D;
        end else begin
            grant = CLIENT_I;
        end
    end

    always_comb begin
        // NOTE: every next-state signal starts from its held value so no path leaves it unassigned (no latches).
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        imem_rdata_d   = imem_rdata_q;
        dmem_rdata_d   = dmem_rdata_q;
        imem_resp_d    = 1'b0;
        dmem_resp_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    last_grant_d = grant;
                    if (grant == CLIENT_D) begin
                        state_d        = SERVE_D;
                        // A simultaneous read+write from the D-cache is a writeback only.
                        pmem_write_d   = dmem_write;
                        pmem_read_d    = ~dmem_write;
                        pmem_address_d = dmem_address & ~OFFSET_MASK;
                        pmem_wdata_d   = dmem_wdata;
                    end else begin
                        state_d        = SERVE_I;
                        pmem_write_d   = 1'b0;
                        pmem_read_d    = 1'b1;
                        pmem_address_d = imem_address & ~OFFSET_MASK;
                        pmem_wdata_d   = '0;
                    end
                end
            end

            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d      = RESP;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    if (state_q == SERVE_I) begin
                        imem_rdata_d = pmem_rdata;
                        imem_resp_d  = 1'b1;
                    end else begin
                        if (pmem_read_q) begin
                            dmem_rdata_d = pmem_rdata;
                        end
                        dmem_resp_d = 1'b1;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= CLIENT_I;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            imem_rdata_q   <= '0;
            dmem_rdata_q   <= '0;
            imem_resp_q    <= 1'b0;
            dmem_resp_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            imem_rdata_q   <= imem_rdata_d;
            dmem_rdata_q   <= dmem_rdata_d;
            imem_resp_q    <= imem_resp_d;
            dmem_resp_q    <= dmem_resp_d;
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign imem_rdata   = imem_rdata_q;
    assign imem_resp    = imem_resp_q;
    assign dmem_rdata   = dmem_rdata_q;
    assign dmem_resp    = dmem_resp_q;

endmodule
